// File: rtl/dl_demux_pkg.sv
// Shared constants for the 1-to-2 stream demux: skid buffer states and port indices.
package dl_demux_pkg;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_TWO   = TWO
  } skid_state_t;
endpackage

// File: rtl/dl_demux_port_buf.sv
// Per-port output buffer, 1-cycle latency, full throughput; single entry with a combinational
// ready path by default, a 2-entry registered-ready skid FIFO when DL_DEMUX_SKID_EN is defined.
module dl_demux_port_buf
  import dl_demux_pkg::*;
#(
  parameter int NUM_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_val,
  output logic                enq_rdy,
  input  logic [NUM_BITS-1:0] enq_data,
  output logic                deq_val,
  input  logic                deq_rdy,
  output logic [NUM_BITS-1:0] deq_data
);

`ifdef DL_DEMUX_SKID_EN
  skid_state_t         r_state;
  logic [NUM_BITS-1:0] r_head;
  logic [NUM_BITS-1:0] r_tail;
  logic                w_enq;
  logic                w_deq;

  // Ready decodes only the state register, so deq_rdy never reaches enq_rdy.
  assign enq_rdy  = (r_state != ST_TWO);
  assign deq_val  = (r_state != ST_EMPTY);
  assign deq_data = r_head;
  assign w_enq    = enq_val && enq_rdy;
  assign w_deq    = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_enq) begin
            r_head  <= enq_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_enq && w_deq) begin
            r_head <= enq_data;
          end else if (w_enq) begin
            r_tail  <= enq_data;
            r_state <= ST_TWO;
          end else if (w_deq) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_deq) begin
            r_head  <= r_tail;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end
`else
  logic                r_val;
  logic [NUM_BITS-1:0] r_data;

  assign enq_rdy  = !r_val || deq_rdy;
  assign deq_val  = r_val;
  assign deq_data = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= 1'b0;
      r_data <= '0;
    end else if (enq_val && enq_rdy) begin
      r_val  <= 1'b1;
      r_data <= enq_data;
    end else if (deq_rdy) begin
      r_val  <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/dl_demux_buf.sv
// 1-to-2 registered stream demux steered by in_sel; each port buffered independently so a
// stalled consumer only backpressures words aimed at it (DL_DEMUX_SKID_EN selects skid buffers).
module dl_demux_buf
  import dl_demux_pkg::*;
#(
  parameter int NUM_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic                in_sel,
  input  logic                in_val,
  output logic                in_rdy,
  output logic [NUM_BITS-1:0] out0_data,
  output logic                out0_val,
  input  logic                out0_rdy,
  output logic [NUM_BITS-1:0] out1_data,
  output logic                out1_val,
  input  logic                out1_rdy
);

  logic w_enq_val0;
  logic w_enq_val1;
  logic w_rdy0;
  logic w_rdy1;

  assign w_enq_val0 = in_val && (in_sel == PORT0);
  assign w_enq_val1 = in_val && (in_sel == PORT1);
  assign in_rdy     = (in_sel == PORT1) ? w_rdy1 : w_rdy0;

  dl_demux_port_buf #(.NUM_BITS(NUM_BITS)) u_port0 (
    .clk      (clk),
    .rst      (rst),
    .enq_val  (w_enq_val0),
    .enq_rdy  (w_rdy0),
    .enq_data (in_data),
    .deq_val  (out0_val),
    .deq_rdy  (out0_rdy),
    .deq_data (out0_data)
  );

  dl_demux_port_buf #(.NUM_BITS(NUM_BITS)) u_port1 (
    .clk      (clk),
    .rst      (rst),
    .enq_val  (w_enq_val1),
    .enq_rdy  (w_rdy1),
    .enq_data (in_data),
    .deq_val  (out1_val),
    .deq_rdy  (out1_rdy),
    .deq_data (out1_data)
  );

endmodule
